// File: rtl/fetch_unit.sv
// SISC fetch unit: program counter, branch-target adder, instruction register and
// instruction-memory read port with a req/ack handshake and a fetch timeout.
module fetch_unit #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_rst,
    input  logic          pc_write,
    input  logic          pc_sel,
    input  logic          br_sel,
    input  logic          ir_load,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] ir,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [15:0]   imm,
    output logic          fetch_busy,
    output logic          ir_valid,
    output logic          fetch_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   fetch_addr;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   target;

    // Branch target from the IR immediate; both forms wrap modulo 2^AW.
    assign target = br_sel ? AW'(imm) : pc + AW'(imm);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= AW'(RESET_VEC);
            ir         <= '0;
            state      <= IDLE;
            fetch_addr <= '0;
            cnt        <= '0;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            ir_valid   <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            if (pc_rst) begin
                pc <= AW'(RESET_VEC);
            end else if (pc_write) begin
                pc <= pc_sel ? target : pc + AW'(1);
            end

            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // fetch_addr takes the PC as it was before any same-cycle pc_write
                    if (ir_load) begin
                        fetch_addr <= pc;
                        cnt        <= '0;
                        state      <= WAIT;
                        imem_req   <= 1'b1;
                        fetch_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        ir         <= imem_rdata;
                        cnt        <= '0;
                        state      <= IDLE;
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                        ir_valid   <= 1'b1;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // memory never answered: load a NOOP and flag it
                        ir         <= '0;
                        fetch_err  <= 1'b1;
                        cnt        <= '0;
                        state      <= IDLE;
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                        ir_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_addr = fetch_addr;
    assign pc_out    = pc;
    assign opcode    = ir[31:28];
    assign mm        = ir[27:24];
    assign imm       = ir[15:0];

endmodule
